// File: rtl/panda_pkg.sv
// Shared types for the panda MEM stage: pipeline register layouts, access widths and LSU states.
package panda_pkg;

  typedef enum logic [1:0] {
    RD_DATA_ALU    = 2'd0,
    RD_DATA_LOAD   = 2'd1,
    RD_DATA_PC_INC = 2'd2,
    RD_DATA_IMM    = 2'd3
  } rd_data_sel_e;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'd0,
    LSU_HALF = 2'd1,
    LSU_WORD = 2'd2
  } lsu_width_e;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } lsu_state_e;

  typedef struct packed {
    logic [31:0]  pc_inc;
    logic [31:0]  alu_result;
    logic [31:0]  imm;
    rd_data_sel_e rd_data_sel;
    logic [4:0]   rd_addr;
    logic         rd_we;
    logic         lsu_store;
    lsu_width_e   lsu_width;
    logic         lsu_load_unsigned;
    logic [31:0]  rs2_data;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0]  pc_inc;
    logic [31:0]  alu_result;
    logic [31:0]  imm;
    rd_data_sel_e rd_data_sel;
    logic [4:0]   rd_addr;
    logic         rd_we;
    logic [31:0]  load_data;
  } mem_wb_t;

  function automatic logic is_misaligned(input lsu_width_e width, input logic [1:0] offset);
    case (width)
      LSU_HALF: is_misaligned = offset[0];
      LSU_WORD: is_misaligned = (offset != 2'b00);
      default:  is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/panda_lsu_align.sv
// Byte-lane steering for the LSU: byte enables, replicated store data and extended load data.
module panda_lsu_align
  import panda_pkg::*;
(
  input  logic [1:0]  offset,
  input  lsu_width_e  width,
  input  logic        load_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[7:0];
    half_lane = rdata[15:0];
    case (offset)
      2'd1: begin byte_lane = rdata[15:8];  half_lane = rdata[23:8]; end
      2'd2: begin byte_lane = rdata[23:16]; half_lane = rdata[31:16]; end
      // a half at offset 3 straddles the word; only the in-word byte survives
      2'd3: begin byte_lane = rdata[31:24]; half_lane = {8'h00, rdata[31:24]}; end
      default: ;
    endcase
  end

  always_comb begin
    be        = 4'b1111;
    wdata     = store_data;
    load_data = rdata;
    case (width)
      LSU_BYTE: begin
        be        = 4'b0001 << offset;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{byte_lane[7] & ~load_unsigned}}, byte_lane};
      end
      LSU_HALF: begin
        be        = 4'b0011 << offset;
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{half_lane[15] & ~load_unsigned}}, half_lane};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/panda_lsu.sv
// MEM-stage load/store unit: request/grant/rvalid handshake FSM and the MEM/WB register.
// Define PANDA_LSU_MISALIGN_CHECK_EN to trap misaligned half/word accesses instead of issuing them.
//
// state       | meaning
// IDLE        | no access outstanding; a memory op here requests in the same cycle
// WAIT_GNT    | request held with stable address/data until the memory grants
// WAIT_RVALID | granted; waiting for the response that completes the access
module panda_lsu
  import panda_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  ex_mem_t     ex_mem_i,
  output mem_wb_t     mem_wb_o,
  output logic        stall_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i,
  output logic        misaligned_o
);

  lsu_state_e  state;
  logic        is_load;
  logic        mem_op;
  logic        misaligned;
  logic        issue;
  logic [31:0] aligned_load;

  assign is_load = (ex_mem_i.rd_data_sel == RD_DATA_LOAD);
  assign mem_op  = is_load | ex_mem_i.lsu_store;

`ifdef PANDA_LSU_MISALIGN_CHECK_EN
  assign misaligned = mem_op && (state == IDLE) &&
                      is_misaligned(ex_mem_i.lsu_width, ex_mem_i.alu_result[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  assign issue        = (state == IDLE) && mem_op && !misaligned;
  assign data_req_o   = issue || (state == WAIT_GNT);
  assign stall_o      = issue || (state == WAIT_GNT) || ((state == WAIT_RVALID) && !data_rvalid_i);
  assign misaligned_o = misaligned;

  // the upstream stall freezes ex_mem_i, which keeps these stable while waiting for grant
  assign data_addr_o = {ex_mem_i.alu_result[31:2], 2'b00};
  assign data_we_o   = ex_mem_i.lsu_store;

  panda_lsu_align u_align (
    .offset        (ex_mem_i.alu_result[1:0]),
    .width         (ex_mem_i.lsu_width),
    .load_unsigned (ex_mem_i.lsu_load_unsigned),
    .store_data    (ex_mem_i.rs2_data),
    .rdata         (data_rdata_i),
    .be            (data_be_o),
    .wdata         (data_wdata_o),
    .load_data     (aligned_load)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      mem_wb_o <= '0;
    end else begin
      case (state)
        IDLE:        if (issue) state <= data_gnt_i ? WAIT_RVALID : WAIT_GNT;
        WAIT_GNT:    if (data_gnt_i) state <= WAIT_RVALID;
        WAIT_RVALID: if (data_rvalid_i) state <= IDLE;
        default:     state <= IDLE;
      endcase

      if (stall_o || misaligned) begin
        mem_wb_o <= '0;
      end else begin
        mem_wb_o.pc_inc      <= ex_mem_i.pc_inc;
        mem_wb_o.alu_result  <= ex_mem_i.alu_result;
        mem_wb_o.imm         <= ex_mem_i.imm;
        mem_wb_o.rd_data_sel <= ex_mem_i.rd_data_sel;
        mem_wb_o.rd_addr     <= ex_mem_i.rd_addr;
        mem_wb_o.rd_we       <= ex_mem_i.rd_we;
        mem_wb_o.load_data   <= is_load ? aligned_load : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_panda_lsu.sv
// Directed bench for panda_lsu: writeback results are scoreboarded, handshake outputs checked inline.
module tb_panda_lsu;
  import panda_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  ex_mem_t     ex_mem;
  mem_wb_t     mem_wb;
  logic        stall, req, gnt, rvalid, we, mis;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;

  always #5 clk = ~clk;

  panda_lsu dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .ex_mem_i      (ex_mem),
    .mem_wb_o      (mem_wb),
    .stall_o       (stall),
    .data_req_o    (req),
    .data_gnt_i    (gnt),
    .data_rvalid_i (rvalid),
    .data_addr_o   (addr),
    .data_we_o     (we),
    .data_be_o     (be),
    .data_wdata_o  (wdata),
    .data_rdata_i  (rdata),
    .misaligned_o  (mis)
  );

  mem_wb_t exp_q[$];
  int      n_vec = 0;
  int      n_err = 0;
  bit      mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic ex_mem_t mk(input rd_data_sel_e sel, input logic st, input lsu_width_e w,
                                 input logic uns, input logic [31:0] a, input logic [31:0] rs2,
                                 input logic [4:0] rd, input logic rd_we);
    ex_mem_t e;
    e = '0;
    e.pc_inc = a + 32'd4;
    e.alu_result = a;
    e.imm = {27'h0, rd} ^ 32'h0000_0700;
    e.rd_data_sel = sel;
    e.rd_addr = rd;
    e.rd_we = rd_we;
    e.lsu_store = st;
    e.lsu_width = w;
    e.lsu_load_unsigned = uns;
    e.rs2_data = rs2;
    return e;
  endfunction

  function automatic mem_wb_t wb(input ex_mem_t e, input logic [31:0] ld);
    mem_wb_t m;
    m.pc_inc = e.pc_inc;
    m.alu_result = e.alu_result;
    m.imm = e.imm;
    m.rd_data_sel = e.rd_data_sel;
    m.rd_addr = e.rd_addr;
    m.rd_we = e.rd_we;
    m.load_data = ld;
    return m;
  endfunction

  // writeback scoreboard: every register-writing result must match the next queued expectation
  always @(negedge clk) begin
    mem_wb_t e;
    if (mon_en && mem_wb.rd_we === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $error("FAIL wb_unexpected: observed alu=%h load=%h expected no writeback",
               mem_wb.alu_result, mem_wb.load_data);
      end else begin
        e = exp_q.pop_front();
        assert (mem_wb === e) else begin
          n_err++;
          $error("FAIL wb_rd%0d: observed alu=%h load=%h pc=%h expected alu=%h load=%h pc=%h",
                 e.rd_addr, mem_wb.alu_result, mem_wb.load_data, mem_wb.pc_inc,
                 e.alu_result, e.load_data, e.pc_inc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input string tag, input ex_mem_t e, input int gnt_dly, input int rv_dly,
                        input logic [31:0] rsp, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_ld);
    ex_mem = e;
    if (e.rd_we) exp_q.push_back(wb(e, exp_ld));
    for (int i = 0; i < gnt_dly; i++) begin
      #1;
      chk({tag, "_req_wait"}, {31'h0, req}, 32'h1);
      chk({tag, "_stall_wait"}, {31'h0, stall}, 32'h1);
      chk({tag, "_addr_wait"}, addr, exp_addr);
      chk({tag, "_be_wait"}, {28'h0, be}, {28'h0, exp_be});
      if (e.lsu_store) chk({tag, "_wdata_wait"}, wdata, exp_wdata);
      step();
    end
    gnt = 1'b1;
    #1;
    chk({tag, "_req"}, {31'h0, req}, 32'h1);
    chk({tag, "_we"}, {31'h0, we}, {31'h0, e.lsu_store});
    chk({tag, "_addr"}, addr, exp_addr);
    chk({tag, "_be"}, {28'h0, be}, {28'h0, exp_be});
    if (e.lsu_store) chk({tag, "_wdata"}, wdata, exp_wdata);
    chk({tag, "_stall_gnt"}, {31'h0, stall}, 32'h1);
    step();
    gnt = 1'b0;
    for (int i = 0; i < rv_dly; i++) begin
      #1;
      chk({tag, "_req_rv"}, {31'h0, req}, 32'h0);
      chk({tag, "_stall_rv"}, {31'h0, stall}, 32'h1);
      step();
    end
    rvalid = 1'b1;
    rdata = rsp;
    #1;
    chk({tag, "_req_done"}, {31'h0, req}, 32'h0);
    chk({tag, "_stall_done"}, {31'h0, stall}, 32'h0);
    step();
    rvalid = 1'b0;
    rdata = 32'h0;
    ex_mem = mk(RD_DATA_ALU, 1'b0, LSU_WORD, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  initial begin
    ex_mem_t nop;
    ex_mem_t e;
    nop = mk(RD_DATA_ALU, 1'b0, LSU_WORD, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    rst = 1'b1; ex_mem = nop; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    repeat (2) step();
    chk("rst_mem_wb_zero", {31'h0, mem_wb == '0}, 32'h1);
    chk("rst_req", {31'h0, req}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_mis", {31'h0, mis}, 32'h0);
    rst = 1'b0;
    mon_en = 1'b1;

    // non-memory op: no request, no stall, visible one edge later
    e = mk(RD_DATA_ALU, 1'b0, LSU_WORD, 1'b0, 32'h0000_0055, 32'h0, 5'd5, 1'b1);
    ex_mem = e;
    exp_q.push_back(wb(e, 32'h0));
    #1;
    chk("add_req", {31'h0, req}, 32'h0);
    chk("add_stall", {31'h0, stall}, 32'h0);
    step();
    ex_mem = nop;
    chk("add_alu_next_edge", mem_wb.alu_result, 32'h0000_0055);

    access("lb", mk(RD_DATA_LOAD, 1'b0, LSU_BYTE, 1'b0, 32'h103, 32'h0, 5'd6, 1'b1),
           0, 0, 32'h80FF_0000, 32'h100, 4'h8, 32'h0, 32'hFFFF_FF80);
    access("sh", mk(RD_DATA_ALU, 1'b1, LSU_HALF, 1'b0, 32'h202, 32'h1234_ABCD, 5'd0, 1'b0),
           3, 0, 32'h0, 32'h200, 4'hC, 32'hABCD_ABCD, 32'h0);
    access("lhu", mk(RD_DATA_LOAD, 1'b0, LSU_HALF, 1'b1, 32'h10, 32'h0, 5'd7, 1'b1),
           0, 1, 32'h0000_8001, 32'h10, 4'h3, 32'h0, 32'h0000_8001);
    access("lh", mk(RD_DATA_LOAD, 1'b0, LSU_HALF, 1'b0, 32'h10, 32'h0, 5'd8, 1'b1),
           1, 0, 32'h0000_8001, 32'h10, 4'h3, 32'h0, 32'hFFFF_8001);
    access("lh_hi", mk(RD_DATA_LOAD, 1'b0, LSU_HALF, 1'b0, 32'h12, 32'h0, 5'd11, 1'b1),
           0, 0, 32'h8001_0000, 32'h10, 4'hC, 32'h0, 32'hFFFF_8001);
    access("lbu", mk(RD_DATA_LOAD, 1'b0, LSU_BYTE, 1'b1, 32'h101, 32'h0, 5'd12, 1'b1),
           0, 0, 32'h0000_AB00, 32'h100, 4'h2, 32'h0, 32'h0000_00AB);
    access("sb", mk(RD_DATA_ALU, 1'b1, LSU_BYTE, 1'b0, 32'h3, 32'h0000_005A, 5'd0, 1'b0),
           1, 1, 32'h0, 32'h0, 4'h8, 32'h5A5A_5A5A, 32'h0);
    access("sw", mk(RD_DATA_ALU, 1'b1, LSU_WORD, 1'b0, 32'h44, 32'hC0FF_EE11, 5'd0, 1'b0),
           0, 0, 32'h0, 32'h44, 4'hF, 32'hC0FF_EE11, 32'h0);
    access("lw", mk(RD_DATA_LOAD, 1'b0, LSU_WORD, 1'b0, 32'h100, 32'h0, 5'd13, 1'b1),
           0, 2, 32'hDEAD_BEEF, 32'h100, 4'hF, 32'h0, 32'hDEAD_BEEF);

`ifdef PANDA_LSU_MISALIGN_CHECK_EN
    ex_mem = mk(RD_DATA_LOAD, 1'b0, LSU_WORD, 1'b0, 32'h101, 32'h0, 5'd9, 1'b1);
    #1;
    chk("lw_mis_req", {31'h0, req}, 32'h0);
    chk("lw_mis_pulse", {31'h0, mis}, 32'h1);
    chk("lw_mis_stall", {31'h0, stall}, 32'h0);
    step();
    ex_mem = nop;
    #1;
    chk("lw_mis_pulse_end", {31'h0, mis}, 32'h0);
    chk("lw_mis_bubble", {31'h0, mem_wb.rd_we}, 32'h0);
`else
    access("lw_mis", mk(RD_DATA_LOAD, 1'b0, LSU_WORD, 1'b0, 32'h101, 32'h0, 5'd9, 1'b1),
           0, 0, 32'h1122_3344, 32'h100, 4'hF, 32'h0, 32'h1122_3344);
    chk("lw_mis_tied", {31'h0, mis}, 32'h0);
`endif

    // reset while waiting for rvalid; the late response must be dropped
    ex_mem = mk(RD_DATA_LOAD, 1'b0, LSU_WORD, 1'b0, 32'h20, 32'h0, 5'd10, 1'b1);
    gnt = 1'b1;
    #1;
    chk("rst_mid_req", {31'h0, req}, 32'h1);
    step();
    gnt = 1'b0;
    chk("rst_mid_wait_stall", {31'h0, stall}, 32'h1);
    rst = 1'b1;
    ex_mem = nop;
    step();
    chk("rst_mid_mem_wb_zero", {31'h0, mem_wb == '0}, 32'h1);
    chk("rst_mid_stall", {31'h0, stall}, 32'h0);
    chk("rst_mid_req_low", {31'h0, req}, 32'h0);
    rst = 1'b0;
    rvalid = 1'b1;
    rdata = 32'hCAFE_F00D;
    step();
    rvalid = 1'b0;
    rdata = 32'h0;
    chk("rst_late_rvalid_rd_we", {31'h0, mem_wb.rd_we}, 32'h0);
    access("post_rst_lb", mk(RD_DATA_LOAD, 1'b0, LSU_BYTE, 1'b0, 32'h21, 32'h0, 5'd14, 1'b1),
           1, 0, 32'h0000_7F00, 32'h20, 4'h2, 32'h0, 32'h0000_007F);

    repeat (2) step();
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/panda_lsu.md
PANDA_LSU -- requirements
Module: panda_lsu

Interface
REQ-001 SHALL have ports clk_i (in, 1, clock) and rst_i (in, 1, reset); one clock, reset synchronous and active-high.
REQ-002 SHALL have ex_mem_i, in, ex_mem_t, MEM-stage input from the EX/MEM register.
REQ-003 SHALL have mem_wb_o, out, mem_wb_t, registered MEM/WB pipeline register.
REQ-004 SHALL have stall_o, out, 1, freeze IF/ID/EX/MEM upstream registers while an access is incomplete.
REQ-005 SHALL have data_req_o (out, 1), data_gnt_i (in, 1), data_rvalid_i (in, 1): data-memory request/grant/response handshake.
REQ-006 SHALL have data_addr_o (out, 32; word-aligned), data_we_o (out, 1), data_be_o (out, 4), data_wdata_o (out, 32), data_rdata_i (in, 32).
REQ-007 SHALL have misaligned_o, out, 1, one-cycle misaligned-access pulse (only meaningful under REQ-024).

Function
REQ-008 SHALL treat ex_mem_i as a load when rd_data_sel==RD_DATA_LOAD, a store when lsu_store=1; otherwise a non-memory op.
REQ-009 SHALL implement FSM IDLE, WAIT_GNT, WAIT_RVALID.
REQ-010 IDLE: memory op present -> data_req_o=1 same cycle; gnt=1 -> WAIT_RVALID, else -> WAIT_GNT.
REQ-011 WAIT_GNT: hold data_req_o=1 and all data_* outputs stable until gnt; then -> WAIT_RVALID.
REQ-012 WAIT_RVALID: data_req_o=0; on rvalid -> IDLE, access complete.
REQ-013 stall_o SHALL be 1 whenever a memory op is present and not complete this cycle; 0 in the cycle rvalid arrives and for non-memory ops.
REQ-014 Non-memory op SHALL pass to mem_wb_o at the next edge (1-cycle latency); memory op SHALL reach mem_wb_o at the edge after rvalid.
REQ-015 While stall_o=1, mem_wb_o SHALL be loaded with a bubble (rd_we=0, other fields don't-care).
REQ-016 data_addr_o = {alu_result[31:2], 2'b00}; data_we_o = lsu_store.
REQ-017 Byte enables: BYTE -> 4'b0001<<a[1:0]; HALF -> 4'b0011<<a[1:0]; WORD -> 4'b1111 (a = alu_result).
REQ-018 Store data SHALL be rs2_data replicated per width (byte x4, half x2, word as-is).
REQ-019 Load data SHALL be the lane selected by a[1:0], sign-extended, or zero-extended when lsu_load_unsigned=1; word loads unmodified.
REQ-020 mem_wb_o SHALL copy pc_inc, alu_result, imm, rd_data_sel, rd_addr, rd_we from ex_mem_i; load_data from REQ-019 (0 for non-loads).
REQ-021 data_rvalid_i in IDLE or WAIT_GNT SHALL be ignored.
REQ-022 Simultaneous gnt and rvalid in the same cycle SHALL not occur; not handled.

Reset
REQ-023 rst_i=1 at an edge SHALL force IDLE, mem_wb_o all-zero (rd_we=0), data_req_o=0, stall_o=0, misaligned_o=0, including mid-access; a late rvalid is then ignored per REQ-021.

Configuration
REQ-024 With PANDA_LSU_MISALIGN_CHECK_EN defined: HALF at a[0]=1 or WORD at a[1:0]!=0 SHALL issue no request, pulse misaligned_o for one cycle, stall_o=0, and write a bubble to mem_wb_o.
REQ-025 Without PANDA_LSU_MISALIGN_CHECK_EN: misaligned_o tied 0; access issued per REQ-016/017 with byte enables truncated to 4 bits (lanes beyond the word dropped).

Structure
REQ-026 lsu_state_e (3 states) and the ex_mem_t/mem_wb_t/lsu_width_e types SHALL live in panda_pkg.
REQ-027 Lane/extend logic (REQ-017..019) SHALL be one combinational sub-module panda_lsu_align; FSM and MEM/WB register SHALL stay in panda_lsu.

Verification
REQ-028 LB, a=0x103, rdata=0x80FF_0000, gnt same cycle, rvalid 1 cycle later -> be=0x8, addr=0x100, stall 1 cycle, load_data=0xFFFF_FF80.
REQ-029 SH, a=0x202, rs2=0x1234_ABCD, gnt delayed 3 cycles -> req/addr/be/wdata stable 3 cycles, be=0xC, wdata=0xABCD_ABCD, stall until rvalid.
REQ-030 LHU, a=0x10, rdata=0x0000_8001 -> load_data=0x0000_8001; LH same -> 0xFFFF_8001.
REQ-031 ADD (rd_data_sel=ALU, rd_we=1) -> no req, stall 0, mem_wb_o.alu_result valid next edge.
REQ-032 rst_i during WAIT_RVALID, rvalid one cycle after reset -> IDLE, mem_wb_o.rd_we=0, rvalid ignored.
REQ-033 LW a=0x101 with macro -> no req, misaligned_o=1 for 1 cycle, bubble; without macro -> req, addr=0x100, be=0xF.
